// File: rtl/dbg_uart_master.sv
// UART 8N1 debug-port initiator: collects 9-byte command frames, drives the core debug
// interface until dbg_ready_i (or timeout), then returns the 32-bit read word over UART.
//
// state   | meaning
// IDLE    | waiting for a non-zero command byte
// RX_ADDR | collecting 4 address bytes (little-endian)
// RX_DATA | collecting 4 write-data bytes (little-endian)
// ISSUE   | command driven to core, waiting for ready or timeout
// RESP    | shifting the 4-byte response out on uart_tx_o
module dbg_uart_master #(
  parameter int          CLK_DIV  = 868,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        err_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLK_DIV - 1);
  // edge detection already costs one cycle, so the half-bit reload is one short
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 2);
  localparam logic [TW-1:0] TMO_LD  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, ISSUE, RESP} state_t;

  rx_state_t     rx_st;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_done, rx_valid, rx_ferr;

  state_t        state, state_nx;
  logic [1:0]    byte_cnt;
  logic [7:0]    cmd_r;
  logic [31:0]   addr_sh, data_sh, resp_word;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [1:0]    tx_byte;
  logic [7:0]    tx_byte_val;
  logic          tx_last;

  assign rx_done  = (rx_st == RX_STOP) && (rx_cnt == '0);
  assign rx_valid = rx_done & rx_s2;
  assign rx_ferr  = rx_done & ~rx_s2;
  assign tx_last  = (state == RESP) && (tx_cnt == '0) && (tx_bit == 4'd9) && (tx_byte == 2'd3);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_s1 <= uart_rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_st)
        RX_IDLE: if (rx_s3 && !rx_s2) begin
          rx_st  <= RX_START;
          rx_cnt <= HALF_LD;
        end
        RX_START: if (rx_cnt == '0) begin
          if (rx_s2) rx_st <= RX_IDLE;
          else begin
            rx_st  <= RX_BITS;
            rx_cnt <= BIT_LD;
            rx_bit <= '0;
          end
        end else rx_cnt <= rx_cnt - 1'b1;
        RX_BITS: if (rx_cnt == '0) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_cnt <= BIT_LD;
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end else rx_cnt <= rx_cnt - 1'b1;
        RX_STOP: if (rx_cnt == '0) rx_st <= RX_IDLE;
                 else rx_cnt <= rx_cnt - 1'b1;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rx_valid && rx_sh != 8'h00) state_nx = RX_ADDR;
      RX_ADDR: if (rx_ferr) state_nx = IDLE;
               else if (rx_valid && byte_cnt == 2'd3) state_nx = RX_DATA;
      RX_DATA: if (rx_ferr) state_nx = IDLE;
               else if (rx_valid && byte_cnt == 2'd3) state_nx = ISSUE;
      ISSUE:   if (dbg_ready_i || tmo_cnt == '0) state_nx = RESP;
      RESP:    if (tx_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != IDLE);
    dbg_cmd_o   = 8'h00;
    uart_tx_o   = 1'b1;
    tx_byte_val = resp_word[{tx_byte, 3'b000} +: 8];
    if (state == ISSUE) dbg_cmd_o = cmd_r;
    if (state == RESP) begin
      if (tx_bit == 4'd0)      uart_tx_o = 1'b0;
      else if (tx_bit <= 4'd8) uart_tx_o = tx_byte_val[3'(tx_bit - 4'd1)];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_cnt   <= '0;
      cmd_r      <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      resp_word  <= '0;
      dbg_addr_o <= '0;
      dbg_data_o <= '0;
      tmo_cnt    <= '0;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_byte    <= '0;
      err_o      <= 1'b0;
    end else begin
      if (rx_ferr) err_o <= 1'b1;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (rx_valid) cmd_r <= rx_sh;
        end
        RX_ADDR: if (rx_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          addr_sh  <= {rx_sh, addr_sh[31:8]};
        end
        RX_DATA: if (rx_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          data_sh  <= {rx_sh, data_sh[31:8]};
          if (byte_cnt == 2'd3) begin
            dbg_addr_o <= addr_sh;
            dbg_data_o <= {rx_sh, data_sh[31:8]};
            tmo_cnt    <= TMO_LD;
          end
        end
        ISSUE: begin
          if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
          if (dbg_ready_i || tmo_cnt == '0) begin
            resp_word <= dbg_ready_i ? dbg_data_i : ERR_WORD;
            if (!dbg_ready_i) err_o <= 1'b1;
            tx_cnt  <= BIT_LD;
            tx_bit  <= '0;
            tx_byte <= '0;
          end
        end
        RESP: if (tx_cnt == '0) begin
          tx_cnt <= BIT_LD;
          if (tx_bit == 4'd9) begin
            tx_bit  <= '0;
            tx_byte <= tx_byte + 1'b1;
          end else tx_bit <= tx_bit + 1'b1;
        end else tx_cnt <= tx_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_uart_master.sv
// Scoreboard bench for dbg_uart_master: host UART driver, debug responder model,
// and independent monitors on the debug interface and the TX line.
module tb_dbg_uart_master;
  localparam int          CLK_DIV  = 4;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o, dbg_data_o;
  logic [31:0] dbg_data_i = '0;
  logic        dbg_ready_i = 1'b0;
  logic        busy_o, err_o;

  dbg_uart_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
    .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i), .busy_o(busy_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } cmd_exp_t;

  cmd_exp_t    exp_cmd_q[$];
  logic [7:0]  exp_byte_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, resp_done = 0, resp_expected = 0;
  int          cur_d = 1;
  logic [31:0] cur_base = '0, cur_step = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Debug responder: ready after cur_d command cycles (0 = never), data changes every cycle.
  initial begin
    int hi = 0;
    forever begin
      @(negedge clk);
      if (dbg_cmd_o !== 8'h00) begin
        hi++;
        dbg_ready_i = (cur_d != 0) && (hi >= cur_d);
        dbg_data_i  = cur_base + 32'(hi) * cur_step;
      end else begin
        hi = 0;
        dbg_ready_i = (cur_d == 1) ? 1'b1 : ((cur_d == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
        dbg_data_i  = $urandom;
      end
    end
  end

  // Debug-interface monitor
  initial begin
    cmd_exp_t   e;
    bit         active = 0;
    int         len = 0;
    logic [7:0] prev = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        active = 0;
        prev = 8'h00;
        continue;
      end
      if (dbg_cmd_o != 8'h00 && prev == 8'h00) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected: got cmd %h expected none", dbg_cmd_o);
        end else begin
          e = exp_cmd_q.pop_front();
          check("cmd", 32'(dbg_cmd_o), 32'(e.cmd));
          check("busy_issue", 32'(busy_o), 32'd1);
          active = 1;
          len = 0;
        end
      end
      if (active && dbg_cmd_o != 8'h00) begin
        len++;
        check("addr", dbg_addr_o, e.addr);
        check("wdata", dbg_data_o, e.data);
      end
      if (active && dbg_cmd_o == 8'h00 && prev != 8'h00) begin
        if (e.len >= 0) check("cmd_len", 32'(len), 32'(e.len));
        check("addr_hold", dbg_addr_o, e.addr);
        check("wdata_hold", dbg_data_o, e.data);
        active = 0;
      end
      prev = dbg_cmd_o;
    end
  end

  // TX line monitor
  initial begin
    int         idx = 0, last_start = 0, st = 0;
    logic [7:0] b;
    logic       prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        idx = 0;
        prev_tx = 1'b1;
        continue;
      end
      if (prev_tx && !uart_tx_o) begin
        st = cyc;
        if (idx > 0) check("tx_gap", 32'(st - last_start), 32'(10 * CLK_DIV));
        last_start = st;
        repeat (CLK_DIV / 2) @(negedge clk);
        check("tx_start", 32'(uart_tx_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (CLK_DIV) @(negedge clk);
        check("tx_stop", 32'(uart_tx_o), 32'd1);
        if (exp_byte_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: got byte %h expected none", b);
        end else check("tx_byte", 32'(b), 32'(exp_byte_q.pop_front()));
        idx = (idx == 3) ? 0 : idx + 1;
        if (idx == 0) begin
          @(negedge clk);
          check("busy_last_stop", 32'(busy_o), 32'd1);
          @(negedge clk);
          check("busy_after_resp", 32'(busy_o), 32'd0);
          resp_done++;
        end
        prev_tx = uart_tx_o;
      end else prev_tx = uart_tx_o;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx_i = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx_i = stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx_i = 1'b1;
    if (!stop) repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    send_byte(cmd, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (resp_done < resp_expected && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (resp_done < resp_expected) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", resp_done, resp_expected);
      resp_done = resp_expected;
    end
  endtask

  // Issue one command; d = ready delay in cycles (0 = never ready).
  task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input int d, input logic [31:0] base, input logic [31:0] step);
    cmd_exp_t    e;
    logic [31:0] word;
    bit          ok = (d >= 1) && (d <= TIMEOUT);
    cur_d = d;
    cur_base = base;
    cur_step = step;
    e.cmd = cmd;
    e.addr = addr;
    e.data = data;
    e.len = ok ? d : TIMEOUT;
    word = ok ? base + 32'(d) * step : ERR_WORD;
    if (!ok) exp_err = 1'b1;
    exp_cmd_q.push_back(e);
    for (int i = 0; i < 4; i++) exp_byte_q.push_back(word[8*i +: 8]);
    resp_expected++;
    send_frame(cmd, addr, data);
    wait_resp();
    repeat (3) @(negedge clk);
    check("err", 32'(err_o), 32'(exp_err));
    check("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    cmd_exp_t e;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_cmd", 32'(dbg_cmd_o), 32'd0);
    check("rst_addr", dbg_addr_o, 32'd0);
    check("rst_data", dbg_data_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk);

    run_cmd(8'h01, 32'h80000010, 32'hDEADBEEF, 3, 32'h12345678, 32'h0);
    run_cmd(8'h5A, $urandom, $urandom, 1, $urandom, $urandom);

    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("err_before_ferr", 32'(err_o), 32'd0);
    send_byte(8'h33, 1'b0);
    repeat (3) @(negedge clk);
    exp_err = 1'b1;
    check("err_ferr", 32'(err_o), 32'd1);
    check("busy_ferr", 32'(busy_o), 32'd0);
    run_cmd(8'h03, $urandom, $urandom, $urandom_range(1, TIMEOUT), $urandom, $urandom);

    send_byte(8'h00, 1'b1);
    run_cmd(8'h04, $urandom, $urandom, $urandom_range(1, TIMEOUT), $urandom, $urandom);

    for (int k = 0; k < 6; k++)
      run_cmd(8'($urandom_range(1, 255)), $urandom, $urandom,
              $urandom_range(1, TIMEOUT), $urandom, $urandom);

    cur_d = 0;
    e.cmd = 8'h07;
    e.addr = 32'hCAFE0004;
    e.data = 32'h0BADF00D;
    e.len = -1;
    exp_cmd_q.push_back(e);
    send_frame(e.cmd, e.addr, e.data);
    repeat (3) @(negedge clk);
    check("cmd_before_rst", 32'(dbg_cmd_o), 32'h07);
    #2 rstn_i = 1'b0;
    #1;
    check("arst_tx", 32'(uart_tx_o), 32'd1);
    check("arst_cmd", 32'(dbg_cmd_o), 32'd0);
    check("arst_addr", dbg_addr_o, 32'd0);
    check("arst_data", dbg_data_o, 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);
    exp_err = 1'b0;
    repeat (5) @(negedge clk);
    rstn_i = 1'b1;
    repeat (100) @(negedge clk);
    check("no_tx_after_rst", 32'(exp_byte_q.size()), 32'd0);
    check("resp_count", 32'(resp_done), 32'(resp_expected));

    run_cmd(8'h08, $urandom, $urandom, 0, $urandom, $urandom);
    run_cmd(8'h09, $urandom, $urandom, TIMEOUT, $urandom, $urandom);
    run_cmd(8'h0A, $urandom, $urandom, $urandom_range(1, TIMEOUT), $urandom, $urandom);

    repeat (20) @(negedge clk);
    check("cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("byte_q_empty", 32'(exp_byte_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
